// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the clock-gate controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    StOff,
    StWake,
    StOn,
    StIdle
  } dom_state_e;

  // Wide enough for SettleCycles up to 15.
  localparam int unsigned SettleW = 4;

endpackage

// File: rtl/clk_gate_ctrl_domain.sv
// One gated clock domain: OFF -> WAKE -> ON <-> IDLE -> OFF with settle and idle counters.
module clk_gate_ctrl_domain
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned SettleCycles = 3,
  parameter int unsigned IdleWidth    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 demand_i,
  input  logic                 grant_i,
  input  logic [IdleWidth-1:0] idle_thresh_i,
  output logic                 en_o,
  output logic                 ack_o,
  output logic                 wake_o,
  output logic                 off_o
);

  dom_state_e           state_q;
  logic                 en_q;
  logic                 ack_q;
  logic [SettleW-1:0]   settle_q;
  logic [IdleWidth-1:0] idle_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StOff;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      settle_q <= '0;
      idle_q   <= '0;
    end else begin
      unique case (state_q)
        StOff: begin
          if (demand_i && grant_i) begin
            state_q  <= StWake;
            en_q     <= 1'b1;
            settle_q <= SettleW'(SettleCycles - 1);
          end
        end
        StWake: begin
          // Demand is ignored here: a started wake always runs to completion.
          if (settle_q == '0) begin
            state_q <= StOn;
            ack_q   <= 1'b1;
          end else begin
            settle_q <= settle_q - SettleW'(1);
          end
        end
        StOn: begin
          if (!demand_i) begin
            state_q <= StIdle;
            idle_q  <= idle_thresh_i;
          end
        end
        StIdle: begin
          // Demand wins over an expiring count; a threshold of 0 behaves like 1.
          if (demand_i) begin
            state_q <= StOn;
          end else if ((idle_q == '0) || (idle_q == IdleWidth'(1))) begin
            state_q <= StOff;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q - IdleWidth'(1);
          end
        end
        default: state_q <= StOff;
      endcase
    end
  end

  assign en_o   = en_q;
  assign ack_o  = ack_q;
  assign wake_o = (state_q == StWake);
  assign off_o  = (state_q == StOff);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gate controller with a single-waker round-robin arbiter.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NumDomains   = 4,
  parameter int unsigned SettleCycles = 3,
  parameter int unsigned IdleWidth    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic [IdleWidth-1:0]  idle_thresh_i,
  input  logic [NumDomains-1:0] req_i,
  input  logic [NumDomains-1:0] busy_i,
  output logic [NumDomains-1:0] en_o,
  output logic [NumDomains-1:0] ack_o,
  output logic                  waking_o
);

  localparam int unsigned PtrW = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  logic [NumDomains-1:0] demand;
  logic [NumDomains-1:0] grant;
  logic [NumDomains-1:0] en_q;
  logic [NumDomains-1:0] wake_st;
  logic [NumDomains-1:0] off_st;
  logic [NumDomains-1:0] off_dem;
  logic                  any_wake;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic                  found;
  int unsigned           idx;

  assign demand   = req_i | busy_i;
  assign off_dem  = off_st & demand;
  assign any_wake = |wake_st;

  // Inrush limit: only grant once the previous waker has fully reached ON.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NumDomains; i++) begin
      idx = (32'(ptr_q) + i) % NumDomains;
      if (!found && !any_wake && off_dem[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = PtrW'((idx + 1) % NumDomains);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar d = 0; d < NumDomains; d++) begin : g_dom
    clk_gate_ctrl_domain #(
      .SettleCycles(SettleCycles),
      .IdleWidth   (IdleWidth)
    ) u_dom (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .demand_i     (demand[d]),
      .grant_i      (grant[d]),
      .idle_thresh_i(idle_thresh_i),
      .en_o         (en_q[d]),
      .ack_o        (ack_o[d]),
      .wake_o       (wake_st[d]),
      .off_o        (off_st[d])
    );
  end

  assign en_o     = en_q | {NumDomains{test_en_i}};
  assign waking_o = any_wake;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed literal checks plus randomized stimulus against a timestamp-based reference model.
module tb_clk_gate_ctrl;

  localparam int NumD   = 4;
  localparam int Settle = 3;
  localparam int IW     = 8;
  localparam int MOff   = 0;
  localparam int MWake  = 1;
  localparam int MOn    = 2;
  localparam int MIdle  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            test_en = 1'b0;
  logic [IW-1:0]   thresh = '0;
  logic [NumD-1:0] req = '0;
  logic [NumD-1:0] busy = '0;
  logic [NumD-1:0] en_o;
  logic [NumD-1:0] ack_o;
  logic            waking_o;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .NumDomains  (NumD),
    .SettleCycles(Settle),
    .IdleWidth   (IW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .test_en_i    (test_en),
    .idle_thresh_i(thresh),
    .req_i        (req),
    .busy_i       (busy),
    .en_o         (en_o),
    .ack_o        (ack_o),
    .waking_o     (waking_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each domain holds a mode and the absolute cycle at which
  // its current WAKE or IDLE phase ends.
  int     mode [NumD];
  longint t_end[NumD];
  longint cyc;
  int     ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NumD; d++) begin
        mode[d]  <= MOff;
        t_end[d] <= 0;
      end
      ptr <= 0;
      cyc <= 0;
    end else begin : step
      int     nm[NumD];
      longint nt[NumD];
      longint cn;
      int     g;
      int     c;
      bit     anyw;
      int     th;
      cn   = cyc + 1;
      anyw = 1'b0;
      for (int d = 0; d < NumD; d++) if (mode[d] == MWake) anyw = 1'b1;
      g = -1;
      if (!anyw) begin
        for (int k = 0; k < NumD; k++) begin
          c = (ptr + k) % NumD;
          if (g < 0 && mode[c] == MOff && (req[c] || busy[c])) g = c;
        end
      end
      th = (int'(thresh) == 0) ? 1 : int'(thresh);
      for (int d = 0; d < NumD; d++) begin
        nm[d] = mode[d];
        nt[d] = t_end[d];
        case (mode[d])
          MOff:  if (g == d) begin nm[d] = MWake; nt[d] = cn + Settle; end
          MWake: if (cn == t_end[d]) nm[d] = MOn;
          MOn:   if (!(req[d] || busy[d])) begin nm[d] = MIdle; nt[d] = cn + th; end
          default: begin
            if (req[d] || busy[d]) nm[d] = MOn;
            else if (cn == t_end[d]) nm[d] = MOff;
          end
        endcase
      end
      for (int d = 0; d < NumD; d++) begin
        mode[d]  <= nm[d];
        t_end[d] <= nt[d];
      end
      if (g >= 0) ptr <= (g + 1) % NumD;
      cyc <= cn;
    end
  end

  always @(negedge clk) begin : cmp
    logic [NumD-1:0] ee;
    logic [NumD-1:0] ea;
    logic            ew;
    ew = 1'b0;
    for (int d = 0; d < NumD; d++) begin
      ee[d] = (mode[d] != MOff) || test_en;
      ea[d] = (mode[d] == MOn) || (mode[d] == MIdle);
      if (mode[d] == MWake) ew = 1'b1;
    end
    check("model_en", 32'(en_o), 32'(ee));
    check("model_ack", 32'(ack_o), 32'(ea));
    check("model_waking", 32'(waking_o), 32'(ew));
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req = '0; busy = '0; test_en = 1'b0; thresh = '0;
    @(negedge clk);
    check("reset_en", 32'(en_o), 32'h0);
    check("reset_ack", 32'(ack_o), 32'h0);
    check("reset_waking", 32'(waking_o), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Single-domain wake latency.
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    check("wake_en_c1", 32'(en_o), 32'h1);
    check("wake_ack_c1", 32'(ack_o), 32'h0);
    repeat (2) @(negedge clk);
    check("wake_ack_c3", 32'(ack_o), 32'h0);
    @(negedge clk);
    check("wake_ack_c4", 32'(ack_o), 32'h1);

    // All four request together: serialized wakes.
    do_reset();
    req = 4'b1111;
    repeat (5) @(negedge clk);
    check("rr_en_c5", 32'(en_o), 32'h3);
    repeat (10) @(negedge clk);
    check("rr_ack_c15", 32'(ack_o), 32'h7);
    @(negedge clk);
    check("rr_ack_c16", 32'(ack_o), 32'hf);

    // Idle threshold 5, then a busy pulse that rescues the domain.
    do_reset();
    thresh = 8'd5;
    req = 4'b0001;
    repeat (4) @(negedge clk);
    #1 req = '0;
    repeat (5) @(negedge clk);
    check("idle5_en_c5", 32'(en_o), 32'h1);
    @(negedge clk);
    check("idle5_en_c6", 32'(en_o), 32'h0);
    #1 req = 4'b0001;
    repeat (4) @(negedge clk);
    #1 req = '0;
    repeat (4) @(negedge clk);
    #1 busy = 4'b0001;
    @(negedge clk);
    #1 busy = '0;
    repeat (3) @(negedge clk);
    check("busy_rescue_en", 32'(en_o), 32'h1);
    check("busy_rescue_ack", 32'(ack_o), 32'h1);
    repeat (3) @(negedge clk);
    check("busy_rescue_off", 32'(en_o), 32'h0);

    // Idle threshold 0.
    #1 begin req = 4'b0001; thresh = '0; end
    repeat (4) @(negedge clk);
    #1 req = '0;
    @(negedge clk);
    check("idle0_en_c1", 32'(en_o), 32'h1);
    @(negedge clk);
    check("idle0_en_c2", 32'(en_o), 32'h0);

    // Reset during domain 2 wake, then rewake.
    do_reset();
    req = 4'b0100;
    repeat (2) @(negedge clk);
    check("midwake_waking", 32'(waking_o), 32'h1);
    check("midwake_en", 32'(en_o), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check("midwake_rst_en", 32'(en_o), 32'h0);
    check("midwake_rst_ack", 32'(ack_o), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rewake_en_c1", 32'(en_o), 32'h4);
    repeat (3) @(negedge clk);
    check("rewake_ack_c4", 32'(ack_o), 32'h4);

    // Test mode forces enables only.
    do_reset();
    test_en = 1'b1;
    @(negedge clk);
    check("test_en_en", 32'(en_o), 32'hf);
    check("test_en_ack", 32'(ack_o), 32'h0);
    #1 test_en = 1'b0;

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(7) == 0) req = 4'($urandom);
      if ($urandom_range(7) == 0) busy = 4'($urandom & $urandom);
      thresh = IW'($urandom_range(6));
      if ($urandom_range(15) == 0) test_en = ~test_en;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(599) == 0) rst_n = 1'b0;
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
